muldiv_iter: RTL
================

// Module: muldiv_iter
// PURPOSE
//  Iterative RV32M-style multiply/divide unit, parametrised in XLEN. Replaces the single-cycle
//  combinational '*' and '/' ALU paths of the single-cycle core. Shift-add multiply and
//  restoring divide, one bit per cycle. Sits beside the ALU; the controller stalls the PC while busy_o.
// PARAMETERS
//  XLEN      32   operand/result width; legal range 4..64
//  CNT_W     $clog2(XLEN)+1   iteration counter width; derived, not overridden
// PORTS
//  clk       in   1     clock, rising edge
//  reset     in   1     asynchronous, active-high
//  start_i   in   1     request; accepted on a rising edge when busy_o==0
//  op_i      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a_i       in   XLEN  rs1 operand (multiplicand / dividend)
//  b_i       in   XLEN  rs2 operand (multiplier / divisor)
//  busy_o    out  1     operation in progress; new start_i ignored
//  done_o    out  1     one-cycle pulse; result_o valid
//  result_o  out  XLEN  result; held from done_o until the next accepted start
// BEHAVIOUR
//  - Reset: state IDLE, busy_o=0, done_o=0, result_o=0, counter=0. Reset mid-operation aborts
//    immediately; the pending result is discarded and no done_o is issued.
//  - FSM: IDLE --start_i--> CALC --counter==XLEN-1--> FIN --> IDLE.
//    FIN applies sign correction, loads result_o and asserts done_o for exactly that cycle.
//  - Latency: start accepted at edge 0. busy_o=1 after edges 0..XLEN. done_o=1, busy_o=0 after
//    edge XLEN+1. Total XLEN+2 edges for every op (but see CONFIGURATION).
//  - Back-to-back: start_i is accepted during the done_o cycle, so there is no dead cycle.
//  - a_i, b_i and op_i are latched at acceptance; changes while busy_o=1 have no effect.
//  - start_i while busy_o=1 is ignored and not queued.
//  - Multiply: signed operands are converted to magnitudes. A 2*XLEN unsigned product is
//    accumulated and negated in FIN if the signs differ.
//    * MUL: low XLEN bits.
//    * MULH: high half, signed x signed.
//    * MULHSU: high half, signed a x unsigned b.
//    * MULHU: high half, unsigned x unsigned.
//  - Divide: magnitudes are used. Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//  - Divide by zero (b==0):
//    * DIV/DIVU -> all ones.
//    * REM/REMU -> a.
//  - Signed overflow (a=MIN_NEG, b=-1):
//    * DIV -> MIN_NEG.
//    * REM -> 0.
//  - Special results are selected in FIN. The datapath must produce no X for any operand value.
//  - All arithmetic wraps modulo 2^XLEN. No exceptions or flags are raised.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//    * Triggers: divide by zero, signed overflow, or any multiply with a_i==0 or b_i==0.
//    * These bypass CALC (IDLE->FIN). done_o is asserted after edge 1 (2-edge latency).
//    * All other ops keep XLEN+2.
//  MULDIV_EARLY_OUT_EN undefined:
//    * Every op takes XLEN+2 edges.
//    * Result values are identical in both builds.
// TESTING (XLEN=32, start at edge 0)
//  1. MUL a=7, b=0xFFFFFFFD -> result_o=0xFFFFFFEB.
//     done_o only after edge 33; busy_o=1 after edges 0..32.
//  2. MULH/MULHSU/MULHU, a=b=0x80000000:
//     MULH -> 0x40000000; MULHSU -> 0xC0000000; MULHU -> 0x40000000.
//  3. DIV a=0xFFFFFFF9(-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
//     DIVU a=100, b=7 -> 14; REMU same operands -> 2.
//  4. DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
//     DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  5. Reset asserted at edge 10 of a DIV -> busy_o=0, done_o=0, result_o=0 immediately.
//     A new MUL 3*4 started afterwards -> 12.
//     Also: start_i pulsed at edge 5 of an active op -> ignored, exactly one done_o.
//  6. Back-to-back: second start_i in the done_o cycle -> second done_o exactly 34 edges later.
//     With MULDIV_EARLY_OUT_EN: DIVU b=0 -> done_o after edge 1, result_o=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_iter: iterative RV32M multiply/divide (shift-add, restoring div)  |
// | Option: MULDIV_EARLY_OUT_EN skips iteration for trivial operands.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [XLEN-1:0]    a_q;
  logic [XLEN-1:0]    m_q;      // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]  prod_q;   // product, or {remainder, quotient}
  logic               neg_q;
  logic               div0_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [XLEN-1:0]    result_q;

  logic               is_div;
  logic               a_sgn;
  logic               b_sgn;
  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic               div0_d;
  logic               ovf_d;
  logic               neg_d;
  logic               early_d;

  // Operand decode at acceptance
  always_comb begin
    is_div  = op_i[2];
    a_sgn   = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    b_sgn   = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    a_neg   = a_sgn & a_i[XLEN-1];
    b_neg   = b_sgn & b_i[XLEN-1];
    a_mag   = a_neg ? -a_i : a_i;
    b_mag   = b_neg ? -b_i : b_i;
    div0_d  = is_div && (b_i == '0);
    ovf_d   = is_div && !op_i[0] && (a_i == C_MIN_NEG) && (b_i == '1);
    neg_d   = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
`ifdef MULDIV_EARLY_OUT_EN
    early_d = div0_d | ovf_d | (!is_div && (a_i == '0 || b_i == '0));
`else
    early_d = 1'b0;
`endif
  end

  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next;
  logic [XLEN:0]      div_shift;
  logic               div_ge;
  logic [XLEN-1:0]    div_diff;
  logic [2*XLEN-1:0]  div_next;

  // One iteration: multiplier bits consumed from prod_q LSB; dividend bits from quotient MSB
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    div_diff  = div_shift[XLEN-1:0] - m_q;
    div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0]  mul_full;
  logic [XLEN-1:0]    div_val;
  logic [XLEN-1:0]    div_res;
  logic [XLEN-1:0]    fin_res;

  always_comb begin
    mul_full = neg_q ? -prod_q : prod_q;
    div_val  = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
    div_res  = neg_q ? -div_val : div_val;
    fin_res  = div_res;
    if (!op_q[2]) begin
      fin_res = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end else if (div0_q) begin
      fin_res = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      fin_res = op_q[1] ? '0 : C_MIN_NEG;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      m_q      <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            a_q     <= a_i;
            m_q     <= is_div ? b_mag : a_mag;
            prod_q  <= early_d ? '0 : {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            neg_q   <= neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= early_d ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          prod_q <= op_q[2] ? div_next : mul_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST) begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          result_q <= fin_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire
